// File: rtl/regfile_dump_engine.sv
// Register-file dump engine: walks a (possibly wrapping) register index
// range, reads each register through a combinational read port and hands
// every word to a ready/valid consumer while keeping a running checksum.
module regfile_dump_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] outAddr,
    output logic [DATA_W-1:0] outData,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] csum_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] cnt_d;
    logic [DATA_W-1:0] csum_d;

    // Next counter value wraps naturally at 2^ADDR_W; checksum wraps at 2^DATA_W.
    assign cnt_d  = cnt_q + ADDR_W'(1);
    assign csum_d = csum_q + out_data_q;

    // Dump sequencer: READ captures one word, SEND holds it until accepted.
    // Flag outputs are registered alongside each state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            end_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            csum_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= firstReg;
                        end_q   <= lastReg;
                        csum_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        out_data_q  <= rdata;
                        out_addr_q  <= cnt_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    // Abort wins over a transfer on the same edge.
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (outReady) begin
                        csum_q      <= csum_d;
                        out_valid_q <= 1'b0;
                        if (cnt_q == end_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= cnt_d;
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign raddr    = cnt_q;
    assign outValid = out_valid_q;
    assign outAddr  = out_addr_q;
    assign outData  = out_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = csum_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Bench for regfile_dump_engine: a queue-based model of the dump (list of
// register indices still to deliver, running sum) checked every cycle,
// directed scenarios with literal expectations, then randomized dumps.
module tb_regfile_dump_engine;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, start, abort, outReady;
    logic [AW-1:0] firstReg, lastReg, raddr, outAddr;
    logic [DW-1:0] rdata, outData, checksum;
    logic          outValid, busy, done;

    logic [DW-1:0] regs [32];

    regfile_dump_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .firstReg(firstReg), .lastReg(lastReg), .raddr(raddr), .rdata(rdata),
        .outValid(outValid), .outReady(outReady), .outAddr(outAddr),
        .outData(outData), .busy(busy), .done(done), .checksum(checksum)
    );

    assign rdata = regs[raddr];

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            q[$];        // register indices still to be delivered
    int            acc_log[$];  // indices accepted by the consumer, in order
    bit            m_send = 0;  // a word is being offered
    bit            m_done = 0;
    logic [DW-1:0] m_sum  = '0;
    bit            chk_en = 0;

    // Check current outputs, then advance the model by the inputs that the
    // next rising edge will sample.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (q.size() > 0) || m_done);
            chk("done", done, m_done);
            chk("outValid", outValid, m_send);
            chk("checksum", checksum, m_sum);
            if (q.size() > 0) chk("raddr", raddr, q[0]);
            if (m_send) begin
                chk("outAddr", outAddr, q[0]);
                chk("outData", outData, regs[q[0]]);
            end
        end
        if (rst) begin
            q.delete();
            m_send = 0; m_done = 0; m_sum = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (q.size() == 0) begin
            if (start) begin
                int n;
                n = ((int'(lastReg) - int'(firstReg) + 32) % 32) + 1;
                for (int k = 0; k < n; k++) q.push_back((int'(firstReg) + k) % 32);
                m_sum = '0; m_send = 0;
            end
        end else if (abort) begin
            q.delete();
            m_send = 0;
        end else if (!m_send) begin
            m_send = 1;
        end else if (outReady) begin
            m_sum = m_sum + regs[q[0]];
            acc_log.push_back(q[0]);
            void'(q.pop_front());
            m_send = 0;
            if (q.size() == 0) m_done = 1;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        start = 0; abort = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic run_to_idle(output int dones);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 0;
            if (done) dones++;
            if (!busy) return;
        end
        chk("dump_timeout", 1, 0);
    endtask

    task automatic kick(input int f, input int l);
        firstReg = AW'(f); lastReg = AW'(l); start = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outValid"}, outValid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_outAddr"}, outAddr, 0);
        chk({tag, "_outData"}, outData, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        int lat, dones;
        logic [DW-1:0] s;
        rst = 1; start = 0; abort = 0; outReady = 1; firstReg = '0; lastReg = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        tick(); tick();
        chk_en = 1;
        chk_all_zero("reset");
        rst = 0;

        // Basic three-word dump with fixed latency.
        regs[1] = 32'h10; regs[2] = 32'h20; regs[3] = 32'h30;
        acc_log.delete();
        kick(1, 3);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); lat++; start = 0;
            if (outValid) break;
        end
        chk("first_valid_latency", lat, 2);
        run_to_idle(dones);
        chk("basic_done_pulses", dones, 1);
        chk("basic_checksum", checksum, 32'h60);
        chk("basic_words", acc_log.size(), 3);

        // Wrapping range 30..1.
        wait_idle();
        regs[30] = 1; regs[31] = 2; regs[0] = 3; regs[1] = 4;
        acc_log.delete();
        kick(30, 1);
        run_to_idle(dones);
        chk("wrap_count", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("wrap_a0", acc_log[0], 30); chk("wrap_a1", acc_log[1], 31);
            chk("wrap_a2", acc_log[2], 0);  chk("wrap_a3", acc_log[3], 1);
        end
        chk("wrap_checksum", checksum, 32'h0A);
        chk("wrap_done_pulses", dones, 1);

        // Backpressure: consumer stalls five cycles on the first word.
        wait_idle();
        outReady = 0;
        kick(5, 7);
        for (int i = 0; i < 10; i++) begin
            tick(); start = 0;
            if (outValid) break;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", outValid, 1);
            chk("stall_addr", outAddr, 5);
            chk("stall_data", outData, regs[5]);
            chk("stall_raddr", raddr, 5);
        end
        outReady = 1;
        run_to_idle(dones);
        s = regs[5] + regs[6] + regs[7];
        chk("stall_checksum", checksum, s);

        // Abort during the second SEND of a four-word dump.
        wait_idle();
        acc_log.delete();
        kick(10, 13);
        for (int i = 0; i < 20; i++) begin
            tick(); start = 0;
            if (outValid && acc_log.size() == 1) break;
        end
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", outValid, 0);
        chk("abort_done", done, 0);
        chk("abort_checksum", checksum, regs[10]);
        kick(2, 2);
        run_to_idle(dones);
        chk("restart_single_done", dones, 1);
        chk("restart_checksum", checksum, regs[2]);

        // Start pulsed while busy is ignored.
        wait_idle();
        acc_log.delete();
        kick(0, 5);
        tick(); start = 0; tick(); tick();
        kick(20, 21);
        run_to_idle(dones);
        chk("busy_start_words", acc_log.size(), 6);

        // Reset mid-dump.
        wait_idle();
        kick(0, 31);
        tick(); start = 0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1; abort = 1; kick(3, 4);
        tick();
        chk_all_zero("midreset");
        rst = 0; abort = 0; start = 0;

        // Randomized dumps.
        for (int d = 0; d < 40; d++) begin
            wait_idle();
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            outReady = 1'($urandom_range(0, 1));
            kick($urandom_range(0, 31), $urandom_range(0, 31));
            for (int c = 0; c < 300; c++) begin
                tick();
                start    = ($urandom_range(0, 3) == 0);
                firstReg = AW'($urandom);
                lastReg  = AW'($urandom);
                outReady = ($urandom_range(0, 3) != 0);
                abort    = ($urandom_range(0, 59) == 0);
                rst      = ($urandom_range(0, 299) == 0);
                if (!busy && c > 0) break;
            end
            rst = 0;
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_engine.md
REGFILE_DUMP_ENGINE -- requirements
Module: regfile_dump_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, cancel an in-progress dump.
REQ-007 SHALL have port firstReg, input, ADDR_W, first register index to dump; sampled with start.
REQ-008 SHALL have port lastReg, input, ADDR_W, last register index to dump; sampled with start.
REQ-009 SHALL have port raddr, output, ADDR_W, read address driven to the register file read port.
REQ-010 SHALL have port rdata, input, DATA_W, combinational read data returned for raddr.
REQ-011 SHALL have port outValid, output, 1, outAddr/outData hold a word for the consumer.
REQ-012 SHALL have port outReady, input, 1, consumer accepts the word.
REQ-013 SHALL have port outAddr, output, ADDR_W, index of the register in outData.
REQ-014 SHALL have port outData, output, DATA_W, captured register value.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the final word is accepted.
REQ-017 SHALL have port checksum, output, DATA_W, running sum of accepted words.

Function
REQ-018 SHALL implement states IDLE, READ, SEND, DONE.
REQ-019 In IDLE with start=1 at an edge, SHALL latch firstReg into the address counter and lastReg into the end register, clear checksum to 0, and enter READ.
REQ-020 In READ, SHALL drive raddr = address counter, capture rdata into outData and the counter into outAddr at the edge, then enter SEND.
REQ-021 In SEND, SHALL hold outValid=1 with outAddr and outData stable until outValid&&outReady at an edge.
REQ-022 On a SEND transfer, SHALL add outData to checksum modulo 2^DATA_W; if counter == end register, SHALL enter DONE, else SHALL increment the counter modulo 2^ADDR_W and enter READ.
REQ-023 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE; checksum SHALL hold its value until the next start.
REQ-024 Minimum throughput SHALL be one word per 2 cycles; start-to-first-outValid latency SHALL be 2 cycles.
REQ-025 If firstReg > lastReg, the counter SHALL wrap 31 -> 0; word count = ((lastReg - firstReg) mod 32) + 1.
REQ-026 If firstReg == lastReg, SHALL dump exactly one word.
REQ-027 start while busy SHALL be ignored; firstReg and lastReg changes while busy SHALL have no effect.
REQ-028 abort=1 at an edge in READ or SEND SHALL return to IDLE with outValid=0, SHALL NOT pulse done, and SHALL leave checksum as accumulated; abort SHALL take priority over a simultaneous transfer.
REQ-029 abort in IDLE or DONE SHALL have no effect, and DONE SHALL still pulse.
REQ-030 outValid SHALL be 1 only in SEND; raddr SHALL equal the counter in all states.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, busy=0, done=0, outValid=0, raddr=0, outAddr=0, outData=0, checksum=0, counter=0, end register=0.
REQ-032 rst SHALL take priority over start, abort and any transfer, including mid-dump.

Verification
REQ-033 Regs r1..r3 = 0x10, 0x20, 0x30; start first=1 last=3, outReady=1 -> words (1,0x10),(2,0x20),(3,0x30), outValid first high 2 cycles after start, done pulses once, checksum=0x60.
REQ-034 first=30 last=1, r30=1, r31=2, r0=3, r1=4 -> addresses 30,31,0,1 in order, checksum=0x0A.
REQ-035 outReady held low 5 cycles during the first SEND -> outAddr/outData stable, no counter advance, dump then completes normally.
REQ-036 abort during the 2nd SEND of a 4-word dump -> IDLE next cycle, no done, checksum = first word only; a new start is then accepted.
REQ-037 rst mid-dump, and start pulsed while busy -> rst gives all outputs 0; start while busy changes neither the sequence nor the word count.
